// File: rtl/bus_arb_pkg.sv
// Shared constants and types for the eight-way round-robin bus arbiter.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (hold-time limited ownership).
package bus_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  // Arbiter ownership state: nobody owns the bus, or one requester does.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Reset value of the last-winner pointer so the first search starts at index 0.
  localparam logic [SEL_W-1:0] LAST_RST = 3'd7;

endpackage

// File: rtl/bus_arb8_rr_pick8.sv
// Combinational round-robin search: first set request bit at or after last+1,
// wrapping modulo 8. The last owner itself is examined last.
module rr_pick8
  import bus_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  // Requests rotated so that rot[0] is index last+1, rot[7] is index last.
  logic [N_REQ-1:0] rot;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    localparam logic [SEL_W-1:0] OFS = SEL_W'(gi + 1);
    assign rot[gi] = req[SEL_W'(last + OFS)];
  end

  logic [SEL_W-1:0] ofs;

  // Lowest set bit of the rotated vector is the distance to the winner.
  always_comb begin
    ofs = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        ofs = SEL_W'(i);
      end
    end
  end

  assign any = |req;
  assign win = last + ofs + 3'd1;

endmodule

// File: rtl/bus_arb8.sv
// Eight-requester round-robin bus arbiter driving the bus mux select.
// Optional feature macro: BUS_ARB_TIMEOUT_EN limits how long one owner may
// keep the bus while others wait (HOLD_MAX cycles).
module bus_arb8
  import bus_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             gnt_new
);

  arb_state_e       state_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;
  logic [N_REQ-1:0] gnt_q;
  logic             valid_q;
  logic             new_q;

  logic [SEL_W-1:0] win;
  logic             any;
  logic             rotate;
  logic             take;
  logic             drop;

  rr_pick8 u_pick (
    .req  (req),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_q;
  logic       others;

  // While granted, gnt_q masks the owner; anything left is a waiting requester.
  assign others = |(req & ~gnt_q);
  assign rotate = (hold_q == HOLD_LAST) && others;

  // Hold counter: cleared on each new grant, counts owner cycles, saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (take) begin
      hold_q <= '0;
    end else if (state_q == GRANT && hold_q != HOLD_LAST) begin
      hold_q <= hold_q + 8'd1;
    end
  end
`else
  // HOLD_MAX only matters with the hold limit built in; fold it away here.
  logic unused_hold;
  assign unused_hold = ^8'(HOLD_MAX);
  assign rotate      = 1'b0;
`endif

  // A new grant is issued from IDLE on any request, or from GRANT when the
  // owner releases (or is forced out) and someone else is waiting.
  assign take = any && ((state_q == IDLE) ||
                        (state_q == GRANT && (!req[sel_q] || rotate)));
  assign drop = (state_q == GRANT) && !req[sel_q] && !any;

  // Ownership FSM with registered select, grant, valid and new-grant pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= LAST_RST;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      new_q   <= 1'b0;
    end else begin
      new_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q <= GRANT;
            sel_q   <= win;
            last_q  <= win;
            gnt_q   <= N_REQ'(1) << win;
            valid_q <= 1'b1;
            new_q   <= 1'b1;
          end
        end
        GRANT: begin
          if (take) begin
            sel_q   <= win;
            last_q  <= win;
            gnt_q   <= N_REQ'(1) << win;
            new_q   <= 1'b1;
          end else if (drop) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_new   = new_q;

endmodule

// File: tb/tb_bus_arb8.sv
// Directed self-checking bench for bus_arb8 (HOLD_MAX = 4).
module tb_bus_arb8;
  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       gnt_new;

  int passed = 0;
  int total  = 0;

  bus_arb8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_new   (gnt_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [2:0] e_sel, input logic [7:0] e_gnt,
                           input logic e_valid, input logic e_new);
    check({tag, ".sel"}, 8'(sel), 8'(e_sel));
    check({tag, ".gnt"}, gnt, e_gnt);
    check({tag, ".valid"}, 8'(gnt_valid), 8'(e_valid));
    check({tag, ".new"}, 8'(gnt_new), 8'(e_new));
    $display("step %s: req=%h sel=%0d gnt=%h valid=%b new=%b", tag, req, sel, gnt, gnt_valid, gnt_new);
  endtask

  logic [2:0] exp_sel9 [9];
  logic       exp_new9 [9];

  initial begin
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check_all("reset", 3'd0, 8'h00, 1'b0, 1'b0);

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("idle%0d", i), 3'd0, 8'h00, 1'b0, 1'b0);
    end

    // First grant goes to 0, then release hands over to 7 with no gap.
    req = 8'h81;
    tick();
    check_all("g81", 3'd0, 8'h01, 1'b1, 1'b1);
    tick();
    check_all("g81hold", 3'd0, 8'h01, 1'b1, 1'b0);
    req = 8'h80;
    tick();
    check_all("rel0", 3'd7, 8'h80, 1'b1, 1'b1);
    req = 8'h00;
    tick();
    check_all("toidle", 3'd7, 8'h00, 1'b0, 1'b0);

    // All requesting; release one owner per grant: order 0,1,...,7,0.
    req = 8'hFF;
    tick();
    check_all("rr0", 3'd0, 8'h01, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] prev;
      logic [2:0] nxt;
      prev = 3'(k - 1);
      nxt  = 3'(k);
      req  = 8'hFF & ~(8'h01 << prev);
      tick();
      check_all($sformatf("rr%0d", k), nxt, 8'h01 << nxt, 1'b1, 1'b1);
      req = 8'hFF;
      tick();
      check_all($sformatf("rrhold%0d", k), nxt, 8'h01 << nxt, 1'b1, 1'b0);
    end
    req = 8'h00;
    tick();
    check_all("rridle", 3'd0, 8'h00, 1'b0, 1'b0);

    // Two constant requesters 1 and 2.
`ifdef BUS_ARB_TIMEOUT_EN
    exp_sel9 = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1};
    exp_new9 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_sel9 = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    exp_new9 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    req = 8'h06;
    for (int c = 0; c < 9; c++) begin
      tick();
      check_all($sformatf("to%0d", c), exp_sel9[c], 8'h01 << exp_sel9[c], 1'b1, exp_new9[c]);
    end
    req = 8'h00;
    tick();
    check_all("toidle2", 3'd1, 8'h00, 1'b0, 1'b0);

    // Single requester 4 held for 20 cycles: one grant pulse only.
    req = 8'h10;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_all($sformatf("single%0d", c), 3'd4, 8'h10, 1'b1, (c == 0));
    end
`ifdef BUS_ARB_TIMEOUT_EN
    check("holdsat", dut.hold_q, 8'd3);
`endif
    req = 8'h00;
    tick();
    check_all("singleidle", 3'd4, 8'h00, 1'b0, 1'b0);

    // Reset mid-grant, then re-grant to 5 after reset drops.
    req = 8'h20;
    tick();
    check_all("g5", 3'd5, 8'h20, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check_all("midrst", 3'd0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_all("regrant5", 3'd5, 8'h20, 1'b1, 1'b1);
    tick();
    check_all("regrant5hold", 3'd5, 8'h20, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bus_arb8.md
# bus_arb8

Round-robin bus arbiter for eight requesters. It produces the 3-bit select that drives the bus's 8:1 select mux, so the mux always forwards the current owner's line. It also provides one-hot grant lines and a valid flag back to the requesters. It sits directly upstream of the mux: its `sel` output connects straight to the mux's `sel` input.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive grant cycles for one owner while others wait. Legal range 2..255. Used only when `BUS_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 8: request lines; bit i is requester i. Level-sensitive, sampled each rising edge.
- `sel` out 3: index of the current or most recent owner; drives the mux select.
- `gnt` out 8: one-hot grant, equal to `1 << sel` when `gnt_valid` is 1, otherwise 8'h00.
- `gnt_valid` out 1: 1 while any requester owns the bus.
- `gnt_new` out 1: one-cycle pulse in the first cycle of each new grant, including re-grant to the same index.

## Operation
- All outputs are registered.
- Reset values:
  - `sel` = 3'd0, `gnt` = 8'h00, `gnt_valid` = 0, `gnt_new` = 0.
  - Internal `last` = 3'd7, so the first search starts at index 0.
  - Hold counter = 0.
- Winner search is combinational over the sampled `req`. It scans indices `last+1`, `last+2`, ... modulo 8 (3-bit wrap) and returns the first set bit. With no bits set there is no winner.
- State IDLE (`gnt_valid` = 0):
  - If `req` != 0 at an edge: go to GRANT. Set `sel` to the winner, `last` to the winner, `gnt_new` to 1, and clear the counter.
  - Otherwise stay in IDLE. `sel` keeps its last value, so the mux output stays defined.
- State GRANT (`gnt_valid` = 1):
  - `req[sel]` = 1 and no forced rotation: stay in GRANT, hold `sel`, `gnt_new` = 0, increment the counter.
  - `req[sel]` = 0 and another bit is set: switch directly to the next winner at that edge, with no idle gap. Searching from `last` skips the releasing owner. `gnt_new` = 1.
  - `req[sel]` = 0 and `req` = 0: go to IDLE. `gnt` = 0, `gnt_valid` = 0, `sel` holds.
- Release is judged only on the sampled level. A one-cycle drop of `req[sel]` counts as a release.
- A released owner that re-requests is served in round-robin order, after other pending requesters.
- Reset asserted at any edge overrides every transition, including mid-grant, and restores the reset values.

## Timing
- Request-to-grant latency: 1 cycle. `req` sampled at edge k gives `gnt`, `sel` and `gnt_valid` valid after edge k.
- Release-to-regrant latency: 1 cycle. `req[sel]` low at edge k gives the new owner after edge k.
- `sel` never changes while `gnt_valid` = 1 except on a `gnt_new` cycle.
- `gnt_new` is never high for two consecutive cycles unless ownership actually changes at each of those edges.
- Worst-case wait for a continuously requesting line with timeout enabled: 7 × `HOLD_MAX` cycles.

## Configuration
- Macro `BUS_ARB_TIMEOUT_EN`, defined:
  - An 8-bit hold counter counts GRANT cycles of the current owner. It is cleared on every `gnt_new`.
  - When the counter equals `HOLD_MAX`-1 and `req` has any bit set other than `sel`, the next edge forces rotation to the next winner, as on a release. `gnt_new` = 1.
  - If no other request is pending, the owner keeps the bus and the counter saturates at `HOLD_MAX`-1.
- Macro not defined: no counter logic, and `HOLD_MAX` is ignored. The owner holds the bus for as long as `req[sel]` stays 1.

## Structure
- Package `bus_arb_pkg` holds:
  - `N_REQ` = 8 and `SEL_W` = 3.
  - The state enum: IDLE, GRANT.
  - The reset constant for `last` (3'd7).
- Sub-module `rr_pick8` holds the combinational search:
  - Inputs: `req[7:0]`, `last[2:0]`.
  - Outputs: `win[2:0]`, `any`.
  - Unit-tested on its own; `bus_arb8` holds the state machine, registers and counter.

## Test plan
- Reset, then `req` = 8'h00 for 5 cycles: `gnt_valid` = 0, `sel` = 0 and `gnt` = 8'h00 throughout.
- After reset, `req` = 8'h81: after 1 edge `sel` = 0, `gnt` = 8'h01 and `gnt_new` pulses once. Drop `req[0]`: next edge `sel` = 7, `gnt` = 8'h80, no idle cycle.
- `req` = 8'hFF held and released one owner per grant: grant order is 0,1,2,...,7,0, and `gnt_new` pulses at each change.
- Timeout enabled with `HOLD_MAX` = 4: `req` = 8'h06 held constantly. Owner 1 for 4 cycles, then owner 2 for 4 cycles, then owner 1.
  - With the macro undefined, owner 1 is held indefinitely.
- Single requester `req` = 8'h10 held for 20 cycles, timeout enabled, `HOLD_MAX` = 4: `sel` = 4 throughout, `gnt_new` pulses only once, and the counter saturates.
- `rst` asserted mid-grant with `sel` = 5: next edge gives all reset values. With `req` = 8'h20 still held, the grant is re-issued to 5 one edge after `rst` drops.
